mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between pipeline fetch (F) and data (M) requests.
//  Sequences each access with a req/ack handshake, returns fetched instruction or load data,
//  and drives per-requester stall signals.
//  Enforces fetch anti-starvation, access timeout and misalignment errors.
//  Sits between the pipelined datapath and the unified memory model.
// PARAMETERS
//  ADDR_W        32  byte-address width
//  DATA_W        32  data/instruction width
//  TIMEOUT       16  max cycles mem_req held without mem_ack before abort (>=2)
//  MAX_DATA_RUN  4   consecutive data grants allowed while a fetch is pending (>=1)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  IReqF       in   1       fetch request; level, held until IReadyF
//  PCF         in   ADDR_W  fetch address
//  InstrF      out  DATA_W  fetched instruction, valid while IReadyF=1
//  IReadyF     out  1       one-cycle fetch completion pulse
//  StallF      out  1       IReqF & fetch not completing this cycle
//  DReqM       in   1       data request; level, held until DReadyM
//  MemWriteM   in   1       1=store, 0=load
//  ALUResultM  in   ADDR_W  data byte address
//  WriteDataM  in   DATA_W  store data
//  ReadDataM   out  DATA_W  load data, valid while DReadyM=1
//  DReadyM     out  1       one-cycle data completion pulse
//  StallM      out  1       DReqM & data not completing this cycle
//  mem_req     out  1       memory request, held until mem_ack or timeout
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory byte address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid with mem_ack
//  mem_ack     in   1       memory completion; sampled only while mem_req=1
//  MemErr      out  1       sticky error flag (timeout or misaligned), cleared only by reset
// BEHAVIOUR
//  Reset (async): state IDLE, counters 0, every output 0; mid-access reset drops mem_req at once; no ready pulse follows.
//  FSM:
//   - IDLE -> DMEM   if DReqM & (data_run<MAX_DATA_RUN | ~IReqF)
//   - IDLE -> IFETCH elif IReqF
//   - IFETCH/DMEM -> RESP on mem_ack, timeout or misalign
//   - RESP -> IDLE
//  Grant (IDLE exit): mem_addr/mem_we/mem_wdata registered from the granted requester; stay stable until exit.
//   - mem_we=0 for fetch; mem_req=1 throughout IFETCH/DMEM.
//  data_run: +1 per data grant (saturating at MAX_DATA_RUN); cleared on fetch grant.
//  mem_ack at cycle t: rdata registered into InstrF/ReadDataM; state RESP at t+1.
//   - In RESP: the matching ready is 1 for exactly that cycle; its Stall is 0.
//  Latency: min 3 cycles request->ready (grant, ack same cycle, RESP); throughput 1 access / 3 cycles.
//  Timeout: wait counter counts cycles in IFETCH/DMEM, clears on grant.
//   - At TIMEOUT without ack: mem_req=0, MemErr=1, RESP with data 0.
//  Misaligned data (ALUResultM[1:0]!=0) at grant: no mem_req; MemErr=1; DMEM->RESP next cycle, ReadDataM=0.
//  Request withdrawn mid-access (flush): access still completes; ready pulse still issued.
//  mem_ack while mem_req=0: ignored.
//  Simultaneous F and M requests: data wins unless the data_run limit is reached.
//  Stall:
//   - StallF = IReqF & ~(state==RESP & last grant fetch)
//   - StallM = DReqM & ~(state==RESP & last grant data); both combinational.
// STRUCTURE
//  Package mem_arb_pkg: arb_state_t enum {IDLE,IFETCH,DMEM,RESP}, grant_t enum {G_FETCH,G_DATA}, ERR_DATA='0.
//  Sub-module arb_wait_timer: load/clear, count enable, expired flag at TIMEOUT.
// TESTING
//  - Fetch only: IReqF=1, PCF=0x10, ack 2 cycles after mem_req, mem_rdata=0x00500093
//    -> mem_addr=0x10, mem_we=0; InstrF=0x00500093 with 1-cycle IReadyF; StallF=1 until that cycle.
//  - Simultaneous IReqF and store (ALUResultM=0x100, WriteDataM=0xDEADBEEF)
//    -> data first (mem_we=1, addr 0x100), then fetch; DReadyM precedes IReadyF.
//  - DReqM and IReqF held continuously, immediate ack
//    -> grant sequence D,D,D,D,F repeating; no fetch waits for more than 4 data grants.
//  - Load with mem_ack never asserted
//    -> mem_req drops after 16 cycles; MemErr=1 sticky; DReadyM pulse with ReadDataM=0.
//  - Load at ALUResultM=0x102 -> mem_req stays 0; MemErr=1; DReadyM pulse with ReadDataM=0.
//  - reset asserted while mem_req=1 -> mem_req=0 same cycle, outputs 0, no ready pulse after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, IFETCH, DMEM, RESP} arb_state_t;

    typedef enum logic {G_FETCH, G_DATA} grant_t;

    // Data returned on an aborted or misaligned access; wide enough for any DATA_W up to 64.
    localparam logic [63:0] ERR_DATA = '0;

endpackage

// File: rtl/arb_wait_timer.sv
// Memory wait timer: down-counter loaded at grant, expired once TIMEOUT wait cycles have elapsed.
module arb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic countEn,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Load on grant, then count down once per wait cycle and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (countEn && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Zero means this is the last wait cycle in which an ack is still accepted.
    assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data accesses.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | no access in flight; picks data or fetch requester
//  IFETCH | fetch access in flight, mem_req held until ack or timeout
//  DMEM   | data access in flight (mem_req suppressed if misaligned)
//  RESP   | one-cycle ready pulse to the requester that was served
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 16,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReqF,
    input  logic [ADDR_W-1:0] PCF,
    output logic [DATA_W-1:0] InstrF,
    output logic              IReadyF,
    output logic              StallF,
    input  logic              DReqM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              DReadyM,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              MemErr
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    arb_state_t        state, stateNext;
    grant_t            lastGrant;
    logic [RUN_W-1:0]  dataRun;
    logic              misalignQ;
    logic [DATA_W-1:0] respData;
    logic              waiting, ackSeen, timerExpired;
    logic              grantData, grantFetch, accessDone;

    assign waiting    = (state == IFETCH) || (state == DMEM);
    assign ackSeen    = mem_ack && mem_req;
    // Data wins ties until it has used up its run while a fetch is waiting.
    assign grantData  = (state == IDLE) && DReqM && ((dataRun < RUN_MAX) || !IReqF);
    assign grantFetch = (state == IDLE) && !grantData && IReqF;
    assign accessDone = waiting && (ackSeen || misalignQ || timerExpired);

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) uWaitTimer (
        .clk     (clk),
        .reset   (reset),
        .load    (grantData || grantFetch),
        .countEn (waiting),
        .expired (timerExpired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        stateNext = state;
        mem_req   = 1'b0;
        IReadyF   = 1'b0;
        DReadyM   = 1'b0;
        case (state)
            IDLE: begin
                if (grantData) begin
                    stateNext = DMEM;
                end else if (grantFetch) begin
                    stateNext = IFETCH;
                end
            end
            IFETCH, DMEM: begin
                mem_req = !misalignQ;
                if (accessDone) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                IReadyF   = (lastGrant == G_FETCH);
                DReadyM   = (lastGrant == G_DATA);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        StallF = IReqF && !IReadyF;
        StallM = DReqM && !DReadyM;
    end

    // Grant capture, data-run accounting, response data and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            lastGrant <= G_FETCH;
            misalignQ <= 1'b0;
            dataRun   <= '0;
            respData  <= '0;
            MemErr    <= 1'b0;
        end else begin
            if (grantData) begin
                mem_addr  <= ALUResultM;
                mem_we    <= MemWriteM;
                mem_wdata <= WriteDataM;
                lastGrant <= G_DATA;
                misalignQ <= |ALUResultM[1:0];
                if (|ALUResultM[1:0]) begin
                    MemErr <= 1'b1;
                end
                if (dataRun != RUN_MAX) begin
                    dataRun <= dataRun + 1'b1;
                end
            end else if (grantFetch) begin
                mem_addr  <= PCF;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                lastGrant <= G_FETCH;
                misalignQ <= 1'b0;
                dataRun   <= '0;
            end
            if (waiting) begin
                if (ackSeen) begin
                    respData <= mem_rdata;
                end else if (misalignQ || timerExpired) begin
                    respData <= ERR_DATA[DATA_W-1:0];
                    MemErr   <= 1'b1;
                end
            end
        end
    end

    // Only the requester currently pulsing ready treats this as valid.
    assign InstrF    = respData;
    assign ReadDataM = respData;

endmodule
